memory_stage: RTL and testbench

MEMORY_STAGE -- requirements
Module: memory_stage

---
 rtl/memory_stage_pkg.sv | 14 +
 rtl/memory_stage_if.sv | 27 ++
 rtl/memory_stage_dff.sv | 18 +
 rtl/memory_stage.sv | 134 +++++++++++++
 tb/tb_memory_stage.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/memory_stage_pkg.sv
// Shared CPU definitions used by the memory stage: FSM state encoding and
// the default access timeout.
package memory_stage_pkg;

   // Default number of WAIT cycles tolerated before an access is abandoned.
   localparam int TIMEOUT_DEFAULT = 15;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/memory_stage_if.sv
// Data-memory bus between the memory stage (master) and the data memory
// (slave).
//
// Handshake: the master raises mem_en for exactly one cycle per access, with
// mem_wr/mem_addr/mem_wdata valid in that same cycle.  The slave answers with
// a single-cycle mem_valid pulse (mem_rdata valid alongside it for reads).
// There is never more than one access outstanding, so no ready/back-pressure
// signal exists; mem_valid arriving while no access is outstanding carries no
// meaning and is ignored by the master.
interface memory_stage_if;
   logic        mem_en;
   logic        mem_wr;
   logic [15:0] mem_addr;
   logic [15:0] mem_wdata;
   logic [15:0] mem_rdata;
   logic        mem_valid;

   modport master (
      output mem_en, mem_wr, mem_addr, mem_wdata,
      input  mem_rdata, mem_valid
   );

   modport slave (
      input  mem_en, mem_wr, mem_addr, mem_wdata,
      output mem_rdata, mem_valid
   );
endinterface

// File: rtl/memory_stage_dff.sv
// 16-bit register with synchronous active-high reset and write enable.
module dff_16bit (
   input  logic        clk,
   input  logic        rst,
   input  logic        wen,
   input  logic [15:0] d,
   output logic [15:0] q
);

   // Clear on reset, otherwise load d when enabled and hold otherwise.
   always_ff @(posedge clk) begin
      if (rst)
         q <= 16'h0000;
      else if (wen)
         q <= d;
   end

endmodule

// File: rtl/memory_stage.sv
// Pipeline memory stage: issues one load/store per request to a variable-
// latency data memory, stalls the pipeline until completion or timeout, and
// then releases it for exactly one DONE cycle.
module memory_stage
   import memory_stage_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           mem_read,
   input  logic           mem_write,
   input  logic [15:0]    addr,
   input  logic [15:0]    wdata,
   memory_stage_if.master mem,
   output logic           stall,
   output logic [15:0]    read_data_out,
   output logic           err,
   output state_t         state_dbg
);

   state_t      state_q, state_d;
   logic [3:0]  cnt_q;
   logic        is_rd_q;
   logic        err_q;

   logic        en_c, wr_c;
   logic [15:0] addr_c, wdata_c;
   logic        stall_c;
   logic        cap_en, set_err, cnt_clr, cnt_inc, issue;
   logic [15:0] cap_d;

   // Next-state, memory strobe, stall and capture decisions for the current state.
   always_comb begin
      state_d = state_q;
      en_c    = 1'b0;
      wr_c    = 1'b0;
      addr_c  = 16'h0000;
      wdata_c = 16'h0000;
      stall_c = 1'b0;
      cap_en  = 1'b0;
      cap_d   = 16'h0000;
      set_err = 1'b0;
      cnt_clr = 1'b0;
      cnt_inc = 1'b0;
      issue   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (mem_read || mem_write) begin
               stall_c = 1'b1;
               if (addr[0]) begin
                  // Misaligned word access never reaches memory.
                  set_err = 1'b1;
                  cap_en  = 1'b1;
                  state_d = ST_DONE;
               end else begin
                  // A simultaneous read+write is carried out as a write.
                  en_c    = 1'b1;
                  wr_c    = mem_write;
                  addr_c  = addr;
                  wdata_c = wdata;
                  set_err = mem_read && mem_write;
                  cnt_clr = 1'b1;
                  issue   = 1'b1;
                  state_d = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            stall_c = 1'b1;
            cnt_inc = 1'b1;
            if (mem.mem_valid) begin
               // Completion takes priority over a timeout in the same cycle.
               cap_en  = is_rd_q;
               cap_d   = mem.mem_rdata;
               state_d = ST_DONE;
            end else if (cnt_q == 4'(TIMEOUT - 1)) begin
               set_err = 1'b1;
               cap_en  = 1'b1;
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      // Reset silences the memory port and the stall in the same cycle.
      if (rst) begin
         en_c    = 1'b0;
         wr_c    = 1'b0;
         stall_c = 1'b0;
      end
   end

   // State, wait counter, access direction and sticky error registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= 4'd0;
         is_rd_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         if (cnt_clr)
            cnt_q <= 4'd0;
         else if (cnt_inc)
            cnt_q <= cnt_q + 4'd1;
         if (issue)
            is_rd_q <= !mem_write;
         if (set_err)
            err_q <= 1'b1;
      end
   end

   dff_16bit u_rdata (
      .clk (clk),
      .rst (rst),
      .wen (cap_en),
      .d   (cap_d),
      .q   (read_data_out)
   );

   assign mem.mem_en    = en_c;
   assign mem.mem_wr    = wr_c;
   assign mem.mem_addr  = addr_c;
   assign mem.mem_wdata = wdata_c;
   assign stall         = stall_c;
   assign err           = err_q;
   assign state_dbg     = state_q;

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: directed scenarios plus randomized
// loads/stores checked against a transaction-level model.
module tb_memory_stage;
   import memory_stage_pkg::*;

   localparam int TO = 15;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_read, mem_write;
   logic [15:0] addr, wdata;
   logic        stall;
   logic [15:0] read_data_out;
   logic        err;
   state_t      state_dbg;

   memory_stage_if mif ();

   memory_stage #(.TIMEOUT(TO)) dut (
      .clk           (clk),
      .rst           (rst),
      .mem_read      (mem_read),
      .mem_write     (mem_write),
      .addr          (addr),
      .wdata         (wdata),
      .mem           (mif.master),
      .stall         (stall),
      .read_data_out (read_data_out),
      .err           (err),
      .state_dbg     (state_dbg)
   );

   // clock
   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   int          en_total = 0;
   logic [15:0] exp_rdo;
   logic        exp_err;
   logic [15:0] exp_q[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reset with outputs checked; model cleared.
   task automatic do_reset();
      rst = 1'b1;
      mem_read = 1'b0;
      mem_write = 1'b0;
      mif.mem_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      exp_rdo = 16'h0000;
      exp_err = 1'b0;
      #1;
      check("rst_state", 32'(state_dbg), 32'(ST_IDLE));
      check("rst_rdo", 32'(read_data_out), 32'h0);
      check("rst_err", 32'(err), 32'h0);
   endtask

   // Idle cycles with stray mem_valid pulses that must be ignored.
   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         mif.mem_valid = 1'($urandom_range(0, 1));
         mif.mem_rdata = 16'($urandom);
         #1;
         check("idle_stall", 32'(stall), 32'h0);
         check("idle_en", 32'(mif.mem_en), 32'h0);
         check("idle_rdo", 32'(read_data_out), 32'(exp_rdo));
         @(negedge clk);
      end
      mif.mem_valid = 1'b0;
   endtask

   // One request: delay = WAIT cycle in which mem_valid is given (>TO: never).
   task automatic run_txn(input logic rd, input logic wr, input logic [15:0] a,
                          input logic [15:0] wd, input int delay,
                          input logic [15:0] vdata, input string tag);
      int          cyc, e, stall_cnt, en_cnt, exp_stall, exp_en;
      logic        seen, done, got_wr;
      logic [15:0] got_a, got_wd, exp_v;
      // transaction-level model
      if (a[0]) begin
         exp_en = 0; exp_stall = 1; exp_err = 1'b1; exp_rdo = 16'h0000;
      end else begin
         exp_en = 1;
         if (rd && wr) exp_err = 1'b1;
         if (delay >= 1 && delay <= TO) begin
            exp_stall = 1 + delay;
            if (!wr) exp_rdo = vdata;
         end else begin
            exp_stall = 1 + TO;
            exp_err = 1'b1;
            exp_rdo = 16'h0000;
         end
      end
      exp_q.push_back(exp_rdo);
      mem_read = rd; mem_write = wr; addr = a; wdata = wd;
      cyc = 0; e = 0; stall_cnt = 0; en_cnt = 0; seen = 0; done = 0;
      got_wr = 0; got_a = 0; got_wd = 0;
      while (!done && cyc < 40) begin
         #1;
         if (mif.mem_en) begin
            en_cnt++;
            if (!seen) begin
               seen = 1; e = cyc; got_wr = mif.mem_wr; got_a = mif.mem_addr; got_wd = mif.mem_wdata;
            end
         end
         if (stall) stall_cnt++;
         else done = 1;
         if (!done) begin
            mif.mem_valid = seen && (cyc - e == delay);
            mif.mem_rdata = mif.mem_valid ? vdata : 16'($urandom);
            @(negedge clk);
            cyc++;
         end
      end
      en_total += en_cnt;
      exp_v = exp_q.pop_front();
      check({tag, "_finished"}, 32'(done), 32'h1);
      check({tag, "_stall_cycles"}, 32'(stall_cnt), 32'(exp_stall));
      check({tag, "_en_pulses"}, 32'(en_cnt), 32'(exp_en));
      if (seen) begin
         check({tag, "_wr"}, 32'(got_wr), 32'(wr));
         check({tag, "_addr"}, 32'(got_a), 32'(a));
         if (wr) check({tag, "_wdata"}, 32'(got_wd), 32'(wd));
      end
      check({tag, "_done_state"}, 32'(state_dbg), 32'(ST_DONE));
      check({tag, "_rdo"}, 32'(read_data_out), 32'(exp_v));
      check({tag, "_err"}, 32'(err), 32'(exp_err));
      // request held through DONE; release it and poke a stray mem_valid
      mem_read = 1'b0; mem_write = 1'b0;
      mif.mem_valid = 1'($urandom_range(0, 1));
      mif.mem_rdata = 16'($urandom);
      @(negedge clk);
      mif.mem_valid = 1'b0;
      #1;
      check({tag, "_back_idle"}, 32'(state_dbg), 32'(ST_IDLE));
      check({tag, "_idle_stall"}, 32'(stall), 32'h0);
      check({tag, "_idle_rdo"}, 32'(read_data_out), 32'(exp_v));
   endtask

   initial begin
      int          k, d, n0;
      logic        rr, ww;
      logic [15:0] ra;
      mem_read = 1'b0; mem_write = 1'b0; addr = 16'h0; wdata = 16'h0;
      mif.mem_valid = 1'b0; mif.mem_rdata = 16'h0;
      exp_rdo = 16'h0; exp_err = 1'b0;

      // reset with a request present: stall and mem_en must stay low
      rst = 1'b1;
      mem_read = 1'b1; addr = 16'h0040;
      @(negedge clk);
      @(negedge clk);
      #1;
      check("rst_req_stall", 32'(stall), 32'h0);
      check("rst_req_en", 32'(mif.mem_en), 32'h0);
      do_reset();
      idle(2);

      // directed cases
      run_txn(1'b1, 1'b0, 16'h0040, 16'h0000, 3, 16'hBEEF, "ld_0040");
      run_txn(1'b0, 1'b1, 16'h0102, 16'h1234, 1, 16'h7777, "st_0102");
      n0 = en_total;
      run_txn(1'b1, 1'b0, 16'h0010, 16'h0000, 2, 16'h1111, "ld_0010");
      run_txn(1'b1, 1'b0, 16'h0012, 16'h0000, 1, 16'h2222, "ld_0012");
      check("b2b_en_pulses", 32'(en_total - n0), 32'd2);
      run_txn(1'b1, 1'b0, 16'h0044, 16'h0000, TO, 16'hC0DE, "ld_valid_at_timeout");
      run_txn(1'b1, 1'b0, 16'h0041, 16'h0000, 1, 16'h3333, "ld_misaligned");
      do_reset();
      run_txn(1'b1, 1'b0, 16'h0080, 16'h0000, 99, 16'h4444, "ld_timeout");
      do_reset();
      run_txn(1'b1, 1'b1, 16'h0200, 16'h5555, 2, 16'h6666, "rw_conflict");

      // reset in WAIT, then a late completion that must be ignored
      do_reset();
      mem_read = 1'b1; addr = 16'h0060;
      #1;
      check("rw_issue_en", 32'(mif.mem_en), 32'h1);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("rw_rst_stall", 32'(stall), 32'h0);
      check("rw_rst_en", 32'(mif.mem_en), 32'h0);
      @(negedge clk);
      rst = 1'b0; mem_read = 1'b0;
      mif.mem_valid = 1'b1; mif.mem_rdata = 16'hAAAA;
      exp_rdo = 16'h0000; exp_err = 1'b0;
      #1;
      check("rw_state", 32'(state_dbg), 32'(ST_IDLE));
      @(negedge clk);
      mif.mem_valid = 1'b0;
      #1;
      check("rw_late_rdo", 32'(read_data_out), 32'h0);
      check("rw_late_err", 32'(err), 32'h0);
      check("rw_late_state", 32'(state_dbg), 32'(ST_IDLE));

      // randomized traffic
      for (int i = 0; i < 30; i++) begin
         if ($urandom_range(0, 4) == 0) do_reset();
         k = $urandom_range(0, 6);
         rr = (k <= 2) || (k == 6);
         ww = (k >= 3);
         ra = 16'($urandom);
         ra[0] = ($urandom_range(0, 5) == 0);
         d = $urandom_range(1, TO + 2);
         run_txn(rr, ww, ra, 16'($urandom), d, 16'($urandom), "rand");
         if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
